// File: rtl/stepper_pos_tracker.sv
// stepper_pos_tracker: rebuilds signed X/Y head position from step/dir/n_en taps, flags wraps and pulses to disabled drivers.
// Latency 0 clk (2 more with STEPPER_POS_TRACKER_SYNC_EN); no backpressure, every rising step edge is taken.
module stepper_pos_tracker #(
  parameter int POS_BITS   = 16,
  parameter int MULT_X     = 1,
  parameter int MULT_Y     = 1,
  parameter int IDLE_TICKS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                in_x,
  input  logic                dir_x,
  input  logic                n_en_x,
  input  logic                in_y,
  input  logic                dir_y,
  input  logic                n_en_y,
  input  logic                load,
  input  logic [POS_BITS-1:0] load_x,
  input  logic [POS_BITS-1:0] load_y,
  input  logic                clear,
  output logic [POS_BITS-1:0] pos_x,
  output logic [POS_BITS-1:0] pos_y,
  output logic                busy,
  output logic                move_done,
  output logic                ovf_x,
  output logic                ovf_y,
  output logic                fault_x,
  output logic                fault_y
);

  localparam int PX_W = (MULT_X > 1) ? $clog2(MULT_X) : 1;
  localparam int PY_W = (MULT_Y > 1) ? $clog2(MULT_Y) : 1;
  localparam int IC_W = $clog2(IDLE_TICKS + 1);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(MULT_X - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(MULT_Y - 1);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IDLE_TICKS - 1);
  localparam logic [POS_BITS-1:0] POS_MAX = {1'b0, {(POS_BITS-1){1'b1}}};
  localparam logic [POS_BITS-1:0] POS_MIN = {1'b1, {(POS_BITS-1){1'b0}}};

  typedef enum logic {S_IDLE, S_MOVING} state_t;

  logic [5:0] drv_raw, drv;
  assign drv_raw = {n_en_y, dir_y, in_y, n_en_x, dir_x, in_x};

`ifdef STEPPER_POS_TRACKER_SYNC_EN
  logic [5:0] sync1_q, sync2_q;
  // Left unreset so a level already present on the pins propagates during reset.
  always_ff @(posedge clk) begin
    sync1_q <= drv_raw;
    sync2_q <= sync1_q;
  end
  assign drv = sync2_q;
`else
  assign drv = drv_raw;
`endif

  logic in_x_s, dir_x_s, n_en_x_s, in_y_s, dir_y_s, n_en_y_s;
  assign {n_en_y_s, dir_y_s, in_y_s, n_en_x_s, dir_x_s, in_x_s} = drv;

  logic [1:0]          in_prev_q, in_prev_d, dir_prev_q, dir_prev_d;
  logic [PX_W-1:0]     ps_x_q, ps_x_d;
  logic [PY_W-1:0]     ps_y_q, ps_y_d;
  logic [POS_BITS-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic                ovf_x_q, ovf_x_d, ovf_y_q, ovf_y_d;
  logic                fault_x_q, fault_x_d, fault_y_q, fault_y_d;
  logic                move_done_q, move_done_d;
  state_t              state_q, state_d;
  logic [IC_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                edge_x, edge_y;
  logic                ovf_set_x, ovf_set_y, fault_set_x, fault_set_y;

  assign edge_x = in_x_s & ~in_prev_q[0];
  assign edge_y = in_y_s & ~in_prev_q[1];

  always_comb begin
    in_prev_d   = {in_y_s, in_x_s};
    dir_prev_d  = {dir_y_s, dir_x_s};
    ps_x_d      = ps_x_q;
    ps_y_d      = ps_y_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    ovf_set_x   = 1'b0;
    ovf_set_y   = 1'b0;
    fault_set_x = 1'b0;
    fault_set_y = 1'b0;

    // A direction change restarts the prescaler before any edge in this cycle is counted.
    if (dir_x_s != dir_prev_q[0]) ps_x_d = '0;
    if (dir_y_s != dir_prev_q[1]) ps_y_d = '0;

    if (edge_x) begin
      fault_set_x = n_en_x_s;
      if (ps_x_d == PX_LAST) begin
        ps_x_d = '0;
        if (dir_x_s) begin
          ovf_set_x = (pos_x_q == POS_MAX);
          pos_x_d   = pos_x_q + POS_BITS'(1);
        end else begin
          ovf_set_x = (pos_x_q == POS_MIN);
          pos_x_d   = pos_x_q - POS_BITS'(1);
        end
      end else begin
        ps_x_d = ps_x_d + PX_W'(1);
      end
    end

    if (edge_y) begin
      fault_set_y = n_en_y_s;
      if (ps_y_d == PY_LAST) begin
        ps_y_d = '0;
        if (dir_y_s) begin
          ovf_set_y = (pos_y_q == POS_MAX);
          pos_y_d   = pos_y_q + POS_BITS'(1);
        end else begin
          ovf_set_y = (pos_y_q == POS_MIN);
          pos_y_d   = pos_y_q - POS_BITS'(1);
        end
      end else begin
        ps_y_d = ps_y_d + PY_W'(1);
      end
    end

    if (load) begin
      pos_x_d     = load_x;
      pos_y_d     = load_y;
      ps_x_d      = '0;
      ps_y_d      = '0;
      ovf_set_x   = 1'b0;
      ovf_set_y   = 1'b0;
      fault_set_x = 1'b0;
      fault_set_y = 1'b0;
    end

    ovf_x_d   = (ovf_x_q   & ~clear) | ovf_set_x;
    ovf_y_d   = (ovf_y_q   & ~clear) | ovf_set_y;
    fault_x_d = (fault_x_q & ~clear) | fault_set_x;
    fault_y_d = (fault_y_q & ~clear) | fault_set_y;

    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    move_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (edge_x || edge_y) begin
          state_d    = S_MOVING;
          idle_cnt_d = '0;
        end
      end
      S_MOVING: begin
        if (edge_x || edge_y) begin
          idle_cnt_d = '0;
        end else if (clk_en) begin
          if (idle_cnt_q == IC_LAST) begin
            state_d     = S_IDLE;
            idle_cnt_d  = '0;
            move_done_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + IC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Edge history follows the inputs through reset: a level held across release is not an edge.
    in_prev_q  <= in_prev_d;
    dir_prev_q <= dir_prev_d;
    if (reset) begin
      ps_x_q      <= '0;
      ps_y_q      <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      ovf_x_q     <= 1'b0;
      ovf_y_q     <= 1'b0;
      fault_x_q   <= 1'b0;
      fault_y_q   <= 1'b0;
      move_done_q <= 1'b0;
      state_q     <= S_IDLE;
      idle_cnt_q  <= '0;
    end else begin
      ps_x_q      <= ps_x_d;
      ps_y_q      <= ps_y_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      ovf_x_q     <= ovf_x_d;
      ovf_y_q     <= ovf_y_d;
      fault_x_q   <= fault_x_d;
      fault_y_q   <= fault_y_d;
      move_done_q <= move_done_d;
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign busy      = (state_q == S_MOVING);
  assign move_done = move_done_q;
  assign ovf_x     = ovf_x_q;
  assign ovf_y     = ovf_y_q;
  assign fault_x   = fault_x_q;
  assign fault_y   = fault_y_q;

endmodule

// File: tb/tb_stepper_pos_tracker.sv
// Directed bench for stepper_pos_tracker: MULT_X=1, MULT_Y=4, IDLE_TICKS=8, POS_BITS=16.
`timescale 1ns/1ps
module tb_stepper_pos_tracker;
  logic        clk = 1'b0;
  logic        reset, clk_en;
  logic        in_x, dir_x, n_en_x, in_y, dir_y, n_en_y;
  logic        load, clear;
  logic [15:0] load_x, load_y;
  logic [15:0] pos_x, pos_y;
  logic        busy, move_done, ovf_x, ovf_y, fault_x, fault_y;

  int checks = 0;
  int errors = 0;
  int md_cnt = 0;
  int md_base;

  stepper_pos_tracker #(.POS_BITS(16), .MULT_X(1), .MULT_Y(4), .IDLE_TICKS(8)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_x(in_x), .dir_x(dir_x), .n_en_x(n_en_x),
    .in_y(in_y), .dir_y(dir_y), .n_en_y(n_en_y),
    .load(load), .load_x(load_x), .load_y(load_y), .clear(clear),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .move_done(move_done),
    .ovf_x(ovf_x), .ovf_y(ovf_y), .fault_x(fault_x), .fault_y(fault_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (move_done === 1'b1) md_cnt <= md_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic px, input logic py);
    in_x = px;
    in_y = py;
    repeat (3) tick();
    in_x = 1'b0;
    in_y = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1;
    in_x = 1'b1; dir_x = 1'b1; n_en_x = 1'b0;
    in_y = 1'b0; dir_y = 1'b0; n_en_y = 1'b0;
    load = 1'b0; clear = 1'b0; load_x = '0; load_y = '0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    chk("rst_pos_x", 32'($signed(pos_x)), 0);
    chk("rst_pos_y", 32'($signed(pos_y)), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_move_done", 32'(move_done), 0);
    chk("rst_flags", 32'({ovf_x, ovf_y, fault_x, fault_y}), 0);
    repeat (5) tick();
    chk("high_at_release_pos_x", 32'($signed(pos_x)), 0);
    chk("high_at_release_busy", 32'(busy), 0);
    in_x = 1'b0;
    repeat (3) tick();

    // Five positive X steps, then idle timeout gated by clk_en.
    md_base = md_cnt;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    chk("t1_pos_x", 32'($signed(pos_x)), 5);
    chk("t1_pos_y", 32'($signed(pos_y)), 0);
    chk("t1_flags", 32'({ovf_x, ovf_y, fault_x, fault_y}), 0);
    chk("t1_busy_moving", 32'(busy), 1);
    clk_en = 1'b0;
    repeat (20) tick();
    chk("t1_busy_no_clk_en", 32'(busy), 1);
    chk("t1_no_done_no_clk_en", md_cnt - md_base, 0);
    clk_en = 1'b1;
    repeat (12) tick();
    chk("t1_busy_after_idle", 32'(busy), 0);
    chk("t1_single_move_done", md_cnt - md_base, 1);

    // Y prescaled by 4, negative then direction flip.
    dir_y = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
    chk("t2_pos_y_3", 32'($signed(pos_y)), 0);
    pulse(1'b0, 1'b1);
    chk("t2_pos_y_4", 32'($signed(pos_y)), -1);
    for (int i = 0; i < 6; i++) pulse(1'b0, 1'b1);
    chk("t2_pos_y_10", 32'($signed(pos_y)), -2);
    dir_y = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1);
    chk("t2_flip_prescaler_cleared", 32'($signed(pos_y)), -2);
    for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1);
    chk("t2_flip_pos_y", 32'($signed(pos_y)), -1);

    // Load near max, wrap in both directions, clear.
    load_x = 16'sd32767; load_y = 16'sd0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("t3_load_pos_x", 32'($signed(pos_x)), 32767);
    chk("t3_load_pos_y", 32'($signed(pos_y)), 0);
    dir_x = 1'b1;
    pulse(1'b1, 1'b0);
    chk("t3_wrap_pos_x", 32'($signed(pos_x)), -32768);
    chk("t3_ovf_x_set", 32'({ovf_x, ovf_y}), 2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_ovf_cleared", 32'({ovf_x, ovf_y}), 0);
    dir_x = 1'b0;
    repeat (2) tick();
    pulse(1'b1, 1'b0);
    chk("t3_underflow_pos_x", 32'($signed(pos_x)), 32767);
    chk("t3_underflow_ovf_x", 32'(ovf_x), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Pulses while driver disabled; clear coincident with second fault edge.
    load_x = 16'sd0; load = 1'b1;
    tick();
    load = 1'b0;
    dir_x = 1'b1; n_en_x = 1'b1;
    repeat (2) tick();
    pulse(1'b1, 1'b0);
    chk("t4_fault_x", 32'({fault_x, fault_y}), 2);
    chk("t4_fault_pos_x", 32'($signed(pos_x)), 1);
    in_x = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (2) tick();
    in_x = 1'b0;
    repeat (3) tick();
    chk("t4_set_beats_clear", 32'(fault_x), 1);
    chk("t4_second_pos_x", 32'($signed(pos_x)), 2);
    n_en_x = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;

    // Load coincident with an X edge drops the edge.
    load_x = 16'sd100; load_y = 16'sd0;
    in_x = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    in_x = 1'b0;
    repeat (3) tick();
    chk("t5_load_wins_pos_x", 32'($signed(pos_x)), 100);
    chk("t5_load_no_fault", 32'({ovf_x, fault_x}), 0);

    // Reset in the middle of a move.
    pulse(1'b1, 1'b0);
    chk("t5_busy_before_reset", 32'(busy), 1);
    md_base = md_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_pos", 32'({pos_x, pos_y}), 0);
    chk("t5_rst_busy_done", 32'({busy, move_done}), 0);
    repeat (15) tick();
    chk("t5_no_move_done", md_cnt - md_base, 0);

    // Overlapping X and Y trains.
    dir_x = 1'b1; dir_y = 1'b1;
    repeat (3) tick();
    md_base = md_cnt;
    for (int i = 0; i < 28; i++) pulse(i < 3, 1'b1);
    chk("t6_pos_x", 32'($signed(pos_x)), 3);
    chk("t6_pos_y", 32'($signed(pos_y)), 7);
    chk("t6_flags", 32'({ovf_x, ovf_y, fault_x, fault_y}), 0);
    chk("t6_no_done_during_move", md_cnt - md_base, 0);
    repeat (15) tick();
    chk("t6_single_move_done", md_cnt - md_base, 1);
    chk("t6_busy_low", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
